ucode_sequencer: RTL and testbench
==================================

# ucode_sequencer

Two-address microcode control unit core for the counter datapath. It holds the micro-program counter (uPC) and the microcode store, and it chooses the next address each cycle from the current word's A/B fields using a selected condition flag. It drives the datapath control lines and sits between the start/abort control inputs and the counter datapath, whose status flags it consumes.

## Interface
- `STATE_W`, 3: uPC width; the store holds 2^STATE_W words.
- `CTRL_W`, 4: control-word width.
- `WDOG_LIMIT`, 255: maximum number of RUN cycles before a watchdog fault. Used only when the watchdog is compiled in.
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin program execution. Sampled only in IDLE.
- `abort`, in, 1: synchronous return to IDLE. Highest priority after reset.
- `cond_in`, in, 3: datapath flags. [0] = count_max, [1] = count_zero, [2] = dir.
- `upc`, out, STATE_W: current micro-address.
- `ctrl_out`, out, CTRL_W: control word of the current uPC while in RUN; 0 otherwise.
- `busy`, out, 1: high while in RUN.
- `done`, out, 1: one-cycle pulse when a halt word retires.
- `fault`, out, 1: one-cycle pulse on a watchdog trip.

## Operation
- Microword fields: `halt`[1], `cond_sel`[2], `addr_a`[STATE_W], `addr_b`[STATE_W], `ctrl`[CTRL_W].
- Condition selection: `cond_sel` 0 → constant 0 (always take A); 1, 2, 3 → `cond_in[0]`, `[1]`, `[2]`.
- Next address: `addr_b` if the selected condition is 1, else `addr_a`. The wrap is implicit in STATE_W bits.
- States:
  - IDLE: `upc` = 0, `ctrl_out` = 0, `busy` = 0.
  - RUN: `ctrl_out` = `ctrl` of `rom[upc]` (combinational), `busy` = 1.
- Transitions, in priority order:
  - `abort` → IDLE, `upc` ← 0, no `done`.
  - IDLE with `start` → RUN, `upc` ← 0.
  - RUN with `halt` = 1 at the current word → IDLE, `upc` ← 0, `done` ← 1.
  - RUN with watchdog trip → IDLE, `upc` ← 0, `fault` ← 1.
  - RUN otherwise → `upc` ← next address.
- `start` is ignored while in RUN. `start` and `abort` asserted together in IDLE: remain in IDLE.
- Halt and watchdog trip on the same cycle: halt wins; `done` pulses, `fault` does not.
- Default program:
  - 0: ctrl 0001 (CLR) → 1
  - 1: ctrl 0010 (LOAD) → 2
  - 2: ctrl 0100 (INC), `cond_sel` = 1, A = 2, B = 3
  - 3: ctrl 1000 (FLAG), halt
  - 4–7: ctrl 0000, halt (traps)

## Timing
- Reset values: `upc` = 0, IDLE, `ctrl_out` = 0, `busy` = 0, `done` = 0, `fault` = 0, watchdog count = 0.
- Start latency: `start` sampled high at edge N → `busy` = 1, `upc` = 0, `ctrl_out` = 0001 during cycle N+1.
- One microword executes per cycle. No stalls.
- `done`/`fault` are registered. They are high for exactly the one cycle after the retiring edge, coincident with `busy` = 0.
- Reset asserted mid-RUN: all outputs go to their reset values immediately, without waiting for a clock edge.

## Configuration
- `UCODE_WATCHDOG_EN` defined:
  - An 8-bit RUN-cycle counter clears when RUN is entered and increments on every RUN cycle.
  - When the count equals `WDOG_LIMIT` and the current word is not a halt, the block forces the trip transition.
- `UCODE_WATCHDOG_EN` not defined: no counter is built, `fault` is tied to 0, and RUN can last indefinitely.

## Structure
- Package `ucode_pkg` contains:
  - the microword typedef (packed struct) and the field widths;
  - the `cond_sel` encodings;
  - the ctrl bit constants CLR, LOAD, INC, FLAG;
  - the default program as a constant array.
- Sub-module `ucode_rom` is a combinational lookup from `upc` to microword, initialised from the package constant.
- Next-address select, state register, watchdog and output gating all live in `ucode_sequencer`.

## Test plan
- Reset then idle: `reset_n` low for 3 cycles, then high with no `start` → `upc` = 0, `ctrl_out` = 0, `busy` = 0 for 10 cycles.
- Full program: `start` pulse, `cond_in[0]` raised on the 4th cycle spent at word 2 → `ctrl_out` sequence 0001, 0010, 0100×4, 1000; then `done` pulses once and `busy` falls.
- Abort during the loop at word 2 → next cycle: IDLE, `upc` = 0, no `done`; a later `start` restarts from word 0.
- `start` while `busy` → ignored; `upc` sequence unchanged.
- With `UCODE_WATCHDOG_EN` and `WDOG_LIMIT` = 8, `cond_in` held 0 → `fault` pulses after 8 RUN cycles and `busy` falls. Without the macro → `busy` stays 1 for 300 cycles and `fault` stays 0.
- `reset_n` asserted mid-RUN at word 2 → `busy`, `ctrl_out` and `upc` go to 0 before the next edge.

Source files
------------

// File: rtl/ucode_pkg.sv
// Shared types and the default microprogram for the two-address microcode sequencer.
// No timing: types, constants and a constructor function only.
// No flow control lives here.
package ucode_pkg;

    localparam int unsigned UPC_W     = 3;
    localparam int unsigned CTRL_BITS = 4;
    localparam int unsigned ROM_DEPTH = 1 << UPC_W;
    localparam int unsigned COND_W    = 3;

    // Which datapath flag steers the A/B choice
    typedef enum logic [1:0] {
        COND_ALWAYS_A = 2'd0,
        COND_MAX      = 2'd1,
        COND_ZERO     = 2'd2,
        COND_DIR      = 2'd3
    } cond_sel_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

    // Control-line bits driven into the counter datapath
    localparam logic [CTRL_BITS-1:0] CTRL_NONE = 4'b0000;
    localparam logic [CTRL_BITS-1:0] CTRL_CLR  = 4'b0001;
    localparam logic [CTRL_BITS-1:0] CTRL_LOAD = 4'b0010;
    localparam logic [CTRL_BITS-1:0] CTRL_INC  = 4'b0100;
    localparam logic [CTRL_BITS-1:0] CTRL_FLAG = 4'b1000;

    typedef struct packed {
        logic                  halt;
        cond_sel_t             cond_sel;
        logic [UPC_W-1:0]      addr_a;
        logic [UPC_W-1:0]      addr_b;
        logic [CTRL_BITS-1:0]  ctrl;
    } microword_t;

    function automatic microword_t mw(input logic halt, input cond_sel_t sel,
                                      input logic [UPC_W-1:0] a, input logic [UPC_W-1:0] b,
                                      input logic [CTRL_BITS-1:0] ctrl);
        microword_t w;
        w.halt     = halt;
        w.cond_sel = sel;
        w.addr_a   = a;
        w.addr_b   = b;
        w.ctrl     = ctrl;
        return w;
    endfunction

    // Clear, load, then spin on INC at word 2 until count_max, flag and halt.
    // Words 4-7 are unreachable traps that halt immediately.
    localparam microword_t DEFAULT_PROG [ROM_DEPTH] = '{
        mw(1'b0, COND_ALWAYS_A, 3'd1, 3'd1, CTRL_CLR),
        mw(1'b0, COND_ALWAYS_A, 3'd2, 3'd2, CTRL_LOAD),
        mw(1'b0, COND_MAX,      3'd2, 3'd3, CTRL_INC),
        mw(1'b1, COND_ALWAYS_A, 3'd0, 3'd0, CTRL_FLAG),
        mw(1'b1, COND_ALWAYS_A, 3'd0, 3'd0, CTRL_NONE),
        mw(1'b1, COND_ALWAYS_A, 3'd0, 3'd0, CTRL_NONE),
        mw(1'b1, COND_ALWAYS_A, 3'd0, 3'd0, CTRL_NONE),
        mw(1'b1, COND_ALWAYS_A, 3'd0, 3'd0, CTRL_NONE)
    };

endpackage

// File: rtl/ucode_rom.sv
// Microcode store: maps a micro-address to its microword.
// Zero latency (purely combinational lookup).
// No backpressure; always answers.
module ucode_rom
    import ucode_pkg::*;
(
    input  logic [UPC_W-1:0] upc,
    output microword_t       word
);

    // Table lookup into the constant default program
    always_comb begin
        word = DEFAULT_PROG[upc];
    end

endmodule

// File: rtl/ucode_sequencer.sv
// Two-address microcode sequencer: uPC register, A/B next-address select, datapath control gating.
// One microword per cycle; start->first word one cycle; done/fault registered one cycle after retire.
// No backpressure or stalls; optional watchdog enabled by defining UCODE_WATCHDOG_EN.
module ucode_sequencer
    import ucode_pkg::*;
#(
    parameter int unsigned STATE_W    = UPC_W,
    parameter int unsigned CTRL_W     = CTRL_BITS,
    parameter int unsigned WDOG_LIMIT = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [2:0]         cond_in,
    output logic [STATE_W-1:0] upc,
    output logic [CTRL_W-1:0]  ctrl_out,
    output logic               busy,
    output logic               done,
    output logic               fault
);

    seq_state_t       state_q, state_d;
    logic [UPC_W-1:0] upc_q, upc_d;
    logic             done_q, done_d;
    logic             fault_d;
    logic             wdog_trip;
    logic             cond_bit;
    logic [UPC_W-1:0] next_addr;
    microword_t       word;

    ucode_rom u_rom (
        .upc  (upc_q),
        .word (word)
    );

    // Pick the steering flag and form the two-way branch target
    always_comb begin
        cond_bit = 1'b0;
        case (word.cond_sel)
            COND_ALWAYS_A: cond_bit = 1'b0;
            COND_MAX:      cond_bit = cond_in[0];
            COND_ZERO:     cond_bit = cond_in[1];
            COND_DIR:      cond_bit = cond_in[2];
            default:       cond_bit = 1'b0;
        endcase
        next_addr = cond_bit ? word.addr_b : word.addr_a;
    end

    // Next state: abort beats everything, then start/halt/watchdog/advance
    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            upc_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        upc_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (word.halt) begin
                        state_d = ST_IDLE;
                        upc_d   = '0;
                        done_d  = 1'b1;
                    end else if (wdog_trip) begin
                        state_d = ST_IDLE;
                        upc_d   = '0;
                        fault_d = 1'b1;
                    end else begin
                        upc_d = next_addr;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    upc_d   = '0;
                end
            endcase
        end
    end

    // State, uPC and done pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            upc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            done_q  <= done_d;
        end
    end

`ifdef UCODE_WATCHDOG_EN
    logic [7:0] wdog_q;
    logic       fault_q;

    // RUN-cycle counter: zero on the first RUN cycle, +1 for each cycle that stays in RUN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
            if (state_q == ST_RUN && state_d == ST_RUN) begin
                wdog_q <= wdog_q + 8'd1;
            end else begin
                wdog_q <= '0;
            end
        end
    end

    assign wdog_trip = (state_q == ST_RUN) && (wdog_q == 8'(WDOG_LIMIT));
    assign fault     = fault_q;
`else
    logic unused_wdog_cfg;

    // No watchdog: RUN may last forever and fault never fires
    assign unused_wdog_cfg = ^{8'(WDOG_LIMIT), fault_d};
    assign wdog_trip       = 1'b0;
    assign fault           = 1'b0;
`endif

    assign busy     = (state_q == ST_RUN);
    assign upc      = upc_q;
    assign ctrl_out = busy ? word.ctrl : '0;
    assign done     = done_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Randomised + directed bench for ucode_sequencer with a per-cycle scoreboard.
// Expected outputs come from a table-driven program model in the bench.
// A monitor on the falling edge pops and compares one expectation per cycle.
module tb_ucode_sequencer;

`ifdef UCODE_WATCHDOG_EN
    localparam int unsigned TB_WDOG = 8;
`else
    localparam int unsigned TB_WDOG = 255;
`endif

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [2:0] cond_in;
    logic [2:0] upc;
    logic [3:0] ctrl_out;
    logic       busy;
    logic       done;
    logic       fault;

    ucode_sequencer #(
        .STATE_W    (3),
        .CTRL_W     (4),
        .WDOG_LIMIT (TB_WDOG)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .cond_in  (cond_in),
        .upc      (upc),
        .ctrl_out (ctrl_out),
        .busy     (busy),
        .done     (done),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference program, written out from the intended microcode listing
    int p_ctrl [8] = '{1, 2, 4, 8, 0, 0, 0, 0};
    int p_halt [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
    int p_sel  [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    int p_a    [8] = '{1, 2, 2, 0, 0, 0, 0, 0};
    int p_b    [8] = '{1, 2, 3, 0, 0, 0, 0, 0};

    typedef struct {
        int upc;
        int ctrl;
        int busy;
        int done;
        int fault;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state
    int m_run, m_pc, m_done, m_fault, m_wd;

    task automatic model_reset();
        m_run = 0; m_pc = 0; m_done = 0; m_fault = 0; m_wd = 0;
    endtask

    task automatic model_step(input logic s, input logic a, input logic [2:0] c);
        int cnd;
        m_done  = 0;
        m_fault = 0;
        if (a) begin
            m_run = 0; m_pc = 0;
        end else if (m_run == 0) begin
            if (s) begin m_run = 1; m_pc = 0; m_wd = 0; end
        end else if (p_halt[m_pc] != 0) begin
            m_run = 0; m_pc = 0; m_done = 1;
`ifdef UCODE_WATCHDOG_EN
        end else if (m_wd == int'(TB_WDOG)) begin
            m_run = 0; m_pc = 0; m_fault = 1;
`endif
        end else begin
            cnd  = (p_sel[m_pc] == 0) ? 0 : int'(c[p_sel[m_pc] - 1]);
            m_pc = (cnd != 0) ? p_b[m_pc] : p_a[m_pc];
            m_wd = m_wd + 1;
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.upc   = m_pc;
        e.ctrl  = (m_run != 0) ? p_ctrl[m_pc] : 0;
        e.busy  = m_run;
        e.done  = m_done;
        e.fault = m_fault;
        exp_q.push_back(e);
    endtask

    // Called just after a rising edge: record this cycle's expectation, drive, advance model
    task automatic drive(input logic s, input logic a, input logic [2:0] c);
        push_expect();
        start   = s;
        abort   = a;
        cond_in = c;
        model_step(s, a, c);
        @(posedge clk);
        #2;
    endtask

    task automatic rst_cycle();
        model_reset();
        push_expect();
        start = 1'b0; abort = 1'b0; cond_in = 3'b000;
        @(posedge clk);
        #2;
    endtask

    // Monitor: one comparison per cycle whenever an expectation is pending
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (int'(upc) != e.upc || int'(ctrl_out) != e.ctrl || int'(busy) != e.busy ||
                int'(done) != e.done || int'(fault) != e.fault) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got upc=%0d ctrl=%0h busy=%0d done=%0d fault=%0d want upc=%0d ctrl=%0h busy=%0d done=%0d fault=%0d",
                         $time, upc, ctrl_out, busy, done, fault,
                         e.upc, e.ctrl, e.busy, e.done, e.fault);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t simulation did not complete", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        cond_in = 3'b000;
        model_reset();
        @(posedge clk);
        #2;

        // Reset held for three cycles, then ten idle cycles
        repeat (3) rst_cycle();
        reset_n = 1'b1;
        repeat (10) drive(1'b0, 1'b0, 3'($urandom_range(0, 7)));

        // Full program: raise count_max on the 4th cycle at word 2
        drive(1'b1, 1'b0, 3'b000);
        n = 0;
        for (int i = 0; i < 20 && m_run != 0; i++) begin
            if (m_pc == 2) n++;
            drive(1'b0, 1'b0, (m_pc == 2 && n >= 4) ? 3'b001 : 3'b000);
        end
        repeat (3) drive(1'b0, 1'b0, 3'b000);

        // Abort while looping at word 2, then restart and finish
        drive(1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 3'b000);
        drive(1'b0, 1'b1, 3'b000);
        drive(1'b0, 1'b0, 3'b000);
        drive(1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 12 && m_run != 0; i++)
            drive(1'b0, 1'b0, (i > 4) ? 3'b001 : 3'b000);

        // start held high during RUN; also start+abort together in IDLE
        drive(1'b1, 1'b1, 3'b000);
        drive(1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 12 && m_run != 0; i++)
            drive(1'b1, 1'b0, (i > 3) ? 3'b001 : 3'b000);
        drive(1'b0, 1'b0, 3'b000);

        // Long run with flags held low: watchdog trip or indefinite RUN
        drive(1'b1, 1'b0, 3'b000);
        repeat (300) drive(1'b0, 1'b0, 3'b000);
        drive(1'b0, 1'b1, 3'b000);
        drive(1'b0, 1'b0, 3'b000);

        // Random traffic
        for (int i = 0; i < 300; i++)
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                  3'($urandom_range(0, 7)));
        drive(1'b0, 1'b1, 3'b000);

        // Asynchronous reset while at word 2
        drive(1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 5 && !(m_run != 0 && m_pc == 2); i++) drive(1'b0, 1'b0, 3'b000);
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || ctrl_out !== 4'd0 || upc !== 3'd0) begin
            errors++;
            $display("FAIL async_reset got busy=%0d ctrl=%0h upc=%0d want busy=0 ctrl=0 upc=0",
                     busy, ctrl_out, upc);
        end
        #1;
        model_reset();
        push_expect();
        @(posedge clk);
        #2;
        rst_cycle();
        reset_n = 1'b1;
        repeat (5) drive(1'b0, 1'b0, 3'b000);
        drive(1'b1, 1'b0, 3'b000);
        repeat (4) drive(1'b0, 1'b0, 3'b000);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
